vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator. Drives the pixel/row counters, sync pulses and blanking flag consumed by the pixel pipeline.
- Generalises the fixed 640x480 timing block: configurable porch/sync/visible widths, sync polarity, pixel-clock-enable gating, and line/frame start strobes.
- Sits at the top of the video path; all pixel-generation logic keys off its outputs.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing_gen_if.sv | 40 ++++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 80 ++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 constants and sync-window helper for vga_timing_gen
package vga_timing_pkg;

    localparam int H_VIS_640  = 640;
    localparam int H_FP_640   = 16;
    localparam int H_SYNC_640 = 96;
    localparam int H_BP_640   = 48;
    localparam int V_VIS_480  = 480;
    localparam int V_FP_480   = 10;
    localparam int V_SYNC_480 = 2;
    localparam int V_BP_480   = 33;

    localparam int H_TOTAL_640 = H_VIS_640 + H_FP_640 + H_SYNC_640 + H_BP_640;
    localparam int V_TOTAL_480 = V_VIS_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

    typedef struct packed {
        int first;
        int last;
        int total;
    } sync_win_t;

    // Sync pulse sits directly after the front porch; first/last are inclusive positions.
    function automatic sync_win_t sync_window(input int vis, input int fp, input int sync, input int bp);
        sync_win_t w;
        w.first = vis + fp;
        w.last  = vis + fp + sync - 1;
        w.total = vis + fp + sync + bp;
        return w;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle; frame_count present only with VGA_FRAME_CNT_EN
interface vga_timing_if #(
    parameter int CNT_W = 10
`ifdef VGA_FRAME_CNT_EN
    ,
    parameter int FRAME_W = 8
`endif
);
    logic             pix_en;
    logic             h_sync;
    logic             v_sync;
    logic [CNT_W-1:0] col_counter;
    logic [CNT_W-1:0] row_counter;
    logic             screen_inactive;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_count;
`endif

    modport master (
        input  pix_en,
        output h_sync, v_sync, col_counter, row_counter,
        output screen_inactive, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
        ,
        output frame_count
`endif
    );

    modport slave (
        output pix_en,
        input  h_sync, v_sync, col_counter, row_counter,
        input  screen_inactive, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
        ,
        input  frame_count
`endif
    );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with registered sync and blank
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_W = 10,
    parameter int VIS   = 640,
    parameter int FP    = 16,
    parameter int SYNC  = 96,
    parameter int BP    = 48,
    parameter bit POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             blank
);

    localparam sync_win_t WIN = sync_window(VIS, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(WIN.total - 1);
    localparam logic [CNT_W-1:0] SYNC_FIRST_C = CNT_W'(WIN.first);
    localparam logic [CNT_W-1:0] SYNC_LAST_C  = CNT_W'(WIN.last);
    localparam logic [CNT_W-1:0] VIS_C        = CNT_W'(VIS);

    if (WIN.total > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_axis_counter: total %0d does not fit CNT_W=%0d", WIN.total, CNT_W);
    end
    if (VIS < 1 || SYNC < 1 || FP < 0 || BP < 0) begin : g_bad_widths
        $error("vga_axis_counter: VIS and SYNC must be >= 1, porches >= 0");
    end

    logic [CNT_W-1:0] count_next;
    logic             sync_next;

    always_comb begin
        count_next = count;
        wrap       = 1'b0;
        if (step) begin
            if (count == LAST_C) begin
                wrap       = 1'b1;
                count_next = '0;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    assign sync_next = (count_next >= SYNC_FIRST_C) && (count_next <= SYNC_LAST_C);

    // Flags register from count_next so they land on the same edge as the count they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sync  <= !POL;
            blank <= 1'b0;
        end else begin
            count <= count_next;
            sync  <= sync_next ? POL : !POL;
            blank <= (count_next >= VIS_C);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator; VGA_FRAME_CNT_EN adds frame_count
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CNT_W  = 10,
    parameter int H_VIS  = H_VIS_640,
    parameter int H_FP   = H_FP_640,
    parameter int H_SYNC = H_SYNC_640,
    parameter int H_BP   = H_BP_640,
    parameter int V_VIS  = V_VIS_480,
    parameter int V_FP   = V_FP_480,
    parameter int V_SYNC = V_SYNC_480,
    parameter int V_BP   = V_BP_480,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
`ifdef VGA_FRAME_CNT_EN
    ,
    parameter int FRAME_W = 8
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    vga_timing_if.master vif
);

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_blank;
    logic             v_blank;

    vga_axis_counter #(
        .CNT_W(CNT_W), .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (vif.pix_en),
        .count (col),
        .wrap  (h_wrap),
        .sync  (vif.h_sync),
        .blank (h_blank)
    );

    vga_axis_counter #(
        .CNT_W(CNT_W), .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (vif.pix_en & h_wrap),
        .count (row),
        .wrap  (v_wrap),
        .sync  (vif.v_sync),
        .blank (v_blank)
    );

    assign vif.col_counter     = col;
    assign vif.row_counter     = row;
    assign vif.screen_inactive = h_blank | v_blank;
    assign vif.line_start      = vif.pix_en && (col == '0);
    assign vif.frame_start     = vif.line_start && (row == '0);

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (v_wrap) begin
            frame_q <= frame_q + 1'b1;
        end
    end

    assign vif.frame_count = frame_q;
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default, short-frame and tiny rasters)
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, fw;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        logic [31:0] col, row, hs, vs, inact, ls, fs, fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    always #5 clk = ~clk;

    vga_timing_if #(.CNT_W(10)) if_a ();
    vga_timing_if #(.CNT_W(10)) if_b ();
`ifdef VGA_FRAME_CNT_EN
    vga_timing_if #(.CNT_W(10), .FRAME_W(2)) if_c ();
`else
    vga_timing_if #(.CNT_W(10)) if_c ();
`endif

    vga_timing_gen u_a (.clk(clk), .rst_n(rst_a), .vif(if_a.master));

    vga_timing_gen #(.V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_b (
        .clk(clk), .rst_n(rst_b), .vif(if_b.master));

    vga_timing_gen #(
        .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1)
`ifdef VGA_FRAME_CNT_EN
        , .FRAME_W(2)
`endif
    ) u_c (.clk(clk), .rst_n(rst_c), .vif(if_c.master));

    cfg_t cfg[3];
    int   m_col[3], m_row[3], m_fc[3];
    int   last_ls[3], ls_gap[3], last_fs[3], fs_gap[3], hs_low[3], vs_low[3];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q[$];
    int   fc_seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_en(input int d, input bit en);
        case (d)
            0: if_a.pix_en = en;
            1: if_b.pix_en = en;
            default: if_c.pix_en = en;
        endcase
    endtask

    task automatic set_rst(input int d, input logic v);
        case (d)
            0: rst_a = v;
            1: rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    `define TB_GRAB(IFX) begin o.col = 32'(IFX.col_counter); o.row = 32'(IFX.row_counter); o.hs = 32'(IFX.h_sync); o.vs = 32'(IFX.v_sync); o.inact = 32'(IFX.screen_inactive); o.ls = 32'(IFX.line_start); o.fs = 32'(IFX.frame_start); end

    function automatic obs_t sample(input int d);
        obs_t o;
        o.fc = '0;
        case (d)
            0: `TB_GRAB(if_a)
            1: `TB_GRAB(if_b)
            default: `TB_GRAB(if_c)
        endcase
`ifdef VGA_FRAME_CNT_EN
        case (d)
            0: o.fc = 32'(if_a.frame_count);
            1: o.fc = 32'(if_b.frame_count);
            default: o.fc = 32'(if_c.frame_count);
        endcase
`endif
        return o;
    endfunction

    function automatic obs_t model_exp(input int d, input bit en);
        obs_t e;
        cfg_t c = cfg[d];
        int col = m_col[d];
        int row = m_row[d];
        bit h_act = (col >= c.hv + c.hf) && (col < c.hv + c.hf + c.hs);
        bit v_act = (row >= c.vv + c.vf) && (row < c.vv + c.vf + c.vs);
        e.col   = 32'(col);
        e.row   = 32'(row);
        e.hs    = 32'(h_act ? c.hpol : !c.hpol);
        e.vs    = 32'(v_act ? c.vpol : !c.vpol);
        e.inact = 32'((col >= c.hv) || (row >= c.vv));
        e.ls    = 32'(en && col == 0);
        e.fs    = 32'(en && col == 0 && row == 0);
        e.fc    = 32'(m_fc[d]);
        return e;
    endfunction

    task automatic advance(input int d);
        cfg_t c = cfg[d];
        m_col[d]++;
        if (m_col[d] == c.hv + c.hf + c.hs + c.hb) begin
            m_col[d] = 0;
            m_row[d]++;
            if (m_row[d] == c.vv + c.vf + c.vs + c.vb) begin
                m_row[d] = 0;
                m_fc[d]  = (m_fc[d] + 1) % (1 << c.fw);
            end
        end
    endtask

    task automatic check_point(input int d, input bit en);
        obs_t e, o;
        string t;
        exp_q.push_back(model_exp(d, en));
        #1;
        o = sample(d);
        e = exp_q.pop_front();
        t = $sformatf("dut%0d r%0d c%0d", d, m_row[d], m_col[d]);
        chk({t, " col"}, o.col, e.col);
        chk({t, " row"}, o.row, e.row);
        chk({t, " h_sync"}, o.hs, e.hs);
        chk({t, " v_sync"}, o.vs, e.vs);
        chk({t, " inactive"}, o.inact, e.inact);
        chk({t, " line_start"}, o.ls, e.ls);
        chk({t, " frame_start"}, o.fs, e.fs);
`ifdef VGA_FRAME_CNT_EN
        chk({t, " frame_count"}, o.fc, e.fc);
`endif
        if (o.ls === 1'b1) begin
            if (last_ls[d] >= 0) ls_gap[d] = cyc - last_ls[d];
            last_ls[d] = cyc;
        end
        if (o.fs === 1'b1) begin
            if (last_fs[d] >= 0) fs_gap[d] = cyc - last_fs[d];
            last_fs[d] = cyc;
            if (d == 2) fc_seen.push_back(int'(o.fc));
        end
        if (o.hs === 1'b0) hs_low[d]++;
        if (o.vs === 1'b0) vs_low[d]++;
    endtask

    task automatic step(input int d, input bit en);
        @(negedge clk);
        set_en(d, en);
        check_point(d, en);
        if (en) advance(d);
        cyc++;
    endtask

    // Reset is applied with pix_en high, checked immediately and across one edge, then released with pix_en low.
    task automatic reset_dut(input int d);
        @(negedge clk);
        set_rst(d, 1'b0);
        set_en(d, 1'b1);
        m_col[d] = 0;
        m_row[d] = 0;
        m_fc[d]  = 0;
        check_point(d, 1'b1);
        @(negedge clk);
        check_point(d, 1'b1);
        set_en(d, 1'b0);
        set_rst(d, 1'b1);
        last_ls[d] = -1; ls_gap[d] = 0; last_fs[d] = -1; fs_gap[d] = 0;
        hs_low[d] = 0; vs_low[d] = 0;
    endtask

    initial begin
        cfg[0] = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, fw:8, hpol:1'b0, vpol:1'b0};
        cfg[1] = '{hv:640, hf:16, hs:96, hb:48, vv:4, vf:1, vs:2, vb:1, fw:8, hpol:1'b0, vpol:1'b0};
        cfg[2] = '{hv:4, hf:1, hs:2, hb:1, vv:3, vf:1, vs:1, vb:1, fw:2, hpol:1'b1, vpol:1'b0};
        if_a.pix_en = 1'b0;
        if_b.pix_en = 1'b0;
        if_c.pix_en = 1'b0;
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        reset_dut(0);
        for (int i = 0; i < 800; i++) step(0, 1'b1);
        chk("dflt h_sync low cycles per line", 32'(hs_low[0]), 32'd96);
        for (int i = 0; i < 900; i++) step(0, 1'b1);
        chk("dflt line period", 32'(ls_gap[0]), 32'd800);
        for (int i = 0; i < 3200; i++) step(0, (i % 2) == 0);
        chk("dflt gated line period", 32'(ls_gap[0]), 32'd1600);
        set_en(0, 1'b0);

        reset_dut(1);
        for (int i = 0; i < 6400; i++) step(1, 1'b1);
        chk("short v_sync low cycles per frame", 32'(vs_low[1]), 32'd1600);
        chk("short h_sync low cycles per frame", 32'(hs_low[1]), 32'd768);
        for (int i = 0; i < 10; i++) step(1, 1'b1);
        chk("short frame period", 32'(fs_gap[1]), 32'd6400);
        set_en(1, 1'b0);

        reset_dut(2);
        for (int i = 0; i < 19; i++) step(2, 1'b1);
        chk("tiny pre-reset row", 32'(m_row[2]), 32'(if_c.row_counter));
        reset_dut(2);
        fc_seen.delete();
        for (int i = 0; i < 288; i++) step(2, 1'b1);
        chk("tiny frame period", 32'(fs_gap[2]), 32'd48);
        chk("tiny frame_start count", 32'(fc_seen.size()), 32'd6);
`ifdef VGA_FRAME_CNT_EN
        for (int i = 0; i < 5 && i < fc_seen.size(); i++)
            chk($sformatf("frame_count at frame %0d", i), 32'(fc_seen[i]), 32'(i % 4));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
